// File: rtl/pci_cfg_space_if.sv
// Config access bus between the PCI target state machine and the config space.
// Requester holds cfg_req (with we/addr/be/wdata) until the one-cycle cfg_ack.
// cfg_rdata is valid while cfg_ack is high and held until the next completed read.
interface pci_cfg_space_if;
  logic        cfg_req;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_ack;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_be, cfg_wdata,
    input  cfg_rdata, cfg_ack
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_be, cfg_wdata,
    output cfg_rdata, cfg_ack
  );
endinterface

// File: rtl/pci_cfg_space.sv
// PCI Type-0 configuration space: ID/class, command/status, BARs, interrupt regs.
// Latency: access performed in the request cycle, ack/rdata registered one cycle later.
// Backpressure: a held request completes every second cycle (request ignored during ack).
module pci_cfg_space #(
  parameter logic [15:0]  VENDOR_ID = 16'h10EE,
  parameter logic [15:0]  DEVICE_ID = 16'h0300,
  parameter logic [31:0]  CLASS_REV = 32'h0B40_0000,
  parameter logic [31:0]  SUBSYS_ID = 32'h0000_0000,
  parameter int           NUM_BARS  = 1,
  parameter logic [191:0] BAR_MASKS = {6{32'hFFFF_FFF0}},
  parameter logic [5:0]   BAR_IO    = 6'b000001,
  parameter logic [5:0]   BAR_PREF  = 6'b000000,
  parameter logic [7:0]   INT_PIN   = 8'h01
) (
  input  logic           clk,
  input  logic           rst,
  pci_cfg_space_if.slave cfg,
  output logic           cmd_io_en_o,
  output logic           cmd_mem_en_o,
  output logic           cmd_master_en_o,
  output logic           cmd_perr_en_o,
  output logic           cmd_serr_en_o,
  output logic           cmd_intx_dis_o,
  output logic [191:0]   bar_base_o,
  input  logic           int_status_i,
  input  logic           set_mabort_i,
  input  logic           set_tabort_i,
  input  logic           set_perr_i,
  input  logic           hit_valid_i,
  input  logic           hit_io_i,
  input  logic [31:0]    hit_addr_i,
  output logic [5:0]     bar_hit_o
);

  localparam logic [15:0] CMD_WMASK = 16'h0547;

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  // Effective size mask: unimplemented BARs behave as absent (mask 0).
  function automatic logic [31:0] bar_mask(input int n);
    if (n < NUM_BARS) return BAR_MASKS[32*n +: 32];
    else              return 32'h0;
  endfunction

  // Hard-wired low type bits; absent BARs read all zero.
  function automatic logic [31:0] bar_type(input int n);
    if (bar_mask(n) == 32'h0) return 32'h0;
    else if (BAR_IO[n])       return 32'h0000_0001;
    else                      return {28'h0, BAR_PREF[n], 3'b000};
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [2:0]  sts_q, sts_d;        // {perr(31), mabort(29), tabort(28)}
  logic [7:0]  cache_q, cache_d;
  logic [7:0]  lat_q, lat_d;
  logic [7:0]  intl_q, intl_d;
  logic [31:0] bar_q [6];           // holds only mask-writable bits
  logic [31:0] bar_d [6];
  logic [31:0] rdata_q, rdata_d;
  logic [5:0]  hit_q, hit_d;
  logic [31:0] bar_rd [6];
  logic [15:0] sts_rd;
  logic [2:0]  sts_clr, sts_set;
  logic        access, wr, rd;

  assign access = (state_q == S_IDLE) && cfg.cfg_req;
  assign wr     = access && cfg.cfg_we;
  assign rd     = access && !cfg.cfg_we;

  for (genvar g = 0; g < 6; g++) begin : g_bar
    assign bar_rd[g]              = (bar_q[g] & bar_mask(g)) | bar_type(g);
    assign bar_base_o[32*g +: 32] = bar_rd[g];
  end

  assign sts_rd = {sts_q[2], 1'b0, sts_q[1], sts_q[0], 8'h00, int_status_i, 3'b000};

  // Handshake FSM: accept in IDLE, pulse ack for one cycle in ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg.cfg_req) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux; the result is captured only on a completed read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (cfg.cfg_addr)
        6'h00:   rdata_d = {DEVICE_ID, VENDOR_ID};
        6'h01:   rdata_d = {sts_rd, cmd_q};
        6'h02:   rdata_d = CLASS_REV;
        6'h03:   rdata_d = {16'h0000, lat_q, cache_q};
        6'h04:   rdata_d = bar_rd[0];
        6'h05:   rdata_d = bar_rd[1];
        6'h06:   rdata_d = bar_rd[2];
        6'h07:   rdata_d = bar_rd[3];
        6'h08:   rdata_d = bar_rd[4];
        6'h09:   rdata_d = bar_rd[5];
        6'h0B:   rdata_d = SUBSYS_ID;
        6'h0F:   rdata_d = {16'h0000, INT_PIN, intl_q};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // Register writes with byte enables; error set pulses override a same-cycle clear.
  always_comb begin
    cmd_d   = cmd_q;
    cache_d = cache_q;
    lat_d   = lat_q;
    intl_d  = intl_q;
    sts_clr = 3'b000;
    sts_set = {set_perr_i, set_mabort_i, set_tabort_i};
    for (int n = 0; n < 6; n++) bar_d[n] = bar_q[n];
    if (wr) begin
      case (cfg.cfg_addr)
        6'h01: begin
          cmd_d = be_merge({16'h0, cmd_q}, cfg.cfg_wdata, cfg.cfg_be)
                  & {16'h0, CMD_WMASK};
          if (cfg.cfg_be[3])
            sts_clr = {cfg.cfg_wdata[31], cfg.cfg_wdata[29], cfg.cfg_wdata[28]};
        end
        6'h03: begin
          if (cfg.cfg_be[0]) cache_d = cfg.cfg_wdata[7:0];
          if (cfg.cfg_be[1]) lat_d   = cfg.cfg_wdata[15:8];
        end
        6'h0F: if (cfg.cfg_be[0]) intl_d = cfg.cfg_wdata[7:0];
        default: ;
      endcase
      for (int n = 0; n < 6; n++) begin
        if (cfg.cfg_addr == 6'(4 + n))
          bar_d[n] = be_merge(bar_q[n], cfg.cfg_wdata, cfg.cfg_be) & bar_mask(n);
      end
    end
    sts_d = (sts_q & ~sts_clr) | sts_set;
  end

  // Per-BAR address decode against the current BAR and enable state.
  always_comb begin
    hit_d = 6'b0;
    for (int n = 0; n < 6; n++) begin
      hit_d[n] = hit_valid_i
              && (bar_mask(n) != 32'h0)
              && (hit_io_i == BAR_IO[n])
              && (BAR_IO[n] ? cmd_q[0] : cmd_q[1])
              && ((hit_addr_i & bar_mask(n)) == (bar_q[n] & bar_mask(n)));
    end
  end

  // State and register file update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      sts_q   <= '0;
      cache_q <= '0;
      lat_q   <= '0;
      intl_q  <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      for (int n = 0; n < 6; n++) bar_q[n] <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sts_q   <= sts_d;
      cache_q <= cache_d;
      lat_q   <= lat_d;
      intl_q  <= intl_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      for (int n = 0; n < 6; n++) bar_q[n] <= bar_d[n];
    end
  end

  assign cfg.cfg_ack   = (state_q == S_ACK);
  assign cfg.cfg_rdata = rdata_q;
  assign bar_hit_o     = hit_q;

  assign cmd_io_en_o     = cmd_q[0];
  assign cmd_mem_en_o    = cmd_q[1];
  assign cmd_master_en_o = cmd_q[2];
  assign cmd_perr_en_o   = cmd_q[6];
  assign cmd_serr_en_o   = cmd_q[8];
  assign cmd_intx_dis_o  = cmd_q[10];

endmodule

// File: tb/tb_pci_cfg_space.sv
// Testbench for pci_cfg_space: directed plan plus randomized accesses vs a reference model.
// Two BARs configured: BAR0 I/O mask FFFF_FFF0, BAR1 prefetchable memory mask FFFF_F000.
// The model updates on each clock; a negedge process compares all outputs every cycle.
module tb_pci_cfg_space;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cmd_io_en, cmd_mem_en, cmd_master_en, cmd_perr_en, cmd_serr_en, cmd_intx_dis;
  logic [191:0] bar_base;
  logic         int_status, set_mabort, set_tabort, set_perr;
  logic         hit_valid, hit_io;
  logic [31:0]  hit_addr;
  logic [5:0]   bar_hit;

  pci_cfg_space_if cif();

  pci_cfg_space #(
    .NUM_BARS (2),
    .BAR_MASKS({{4{32'hFFFF_FFF0}}, 32'hFFFF_F000, 32'hFFFF_FFF0}),
    .BAR_IO   (6'b000001),
    .BAR_PREF (6'b000010)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cif),
    .cmd_io_en_o    (cmd_io_en),
    .cmd_mem_en_o   (cmd_mem_en),
    .cmd_master_en_o(cmd_master_en),
    .cmd_perr_en_o  (cmd_perr_en),
    .cmd_serr_en_o  (cmd_serr_en),
    .cmd_intx_dis_o (cmd_intx_dis),
    .bar_base_o     (bar_base),
    .int_status_i   (int_status),
    .set_mabort_i   (set_mabort),
    .set_tabort_i   (set_tabort),
    .set_perr_i     (set_perr),
    .hit_valid_i    (hit_valid),
    .hit_io_i       (hit_io),
    .hit_addr_i     (hit_addr),
    .bar_hit_o      (bar_hit)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_mask(input int n);
    case (n)
      0:       return 32'hFFFF_FFF0;
      1:       return 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_type(input int n);
    case (n)
      0:       return 32'h1;
      1:       return 32'h8;
      default: return 32'h0;
    endcase
  endfunction

  logic [15:0] m_cmd;
  logic        m_perr, m_mab, m_tab;
  logic [7:0]  m_cache, m_lat, m_intl;
  logic [31:0] m_bar [6];
  logic        exp_ack;
  logic [31:0] exp_rdata;
  logic [5:0]  exp_hit;

  function automatic logic [31:0] m_bar_rd(input int n);
    return (m_bar[n] & m_mask(n)) | m_type(n);
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'h00: return 32'h0300_10EE;
      6'h01: return {m_perr, 1'b0, m_mab, m_tab, 8'h00, int_status, 3'b000, m_cmd};
      6'h02: return 32'h0B40_0000;
      6'h03: return {16'h0, m_lat, m_cache};
      6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09: return m_bar_rd(int'(a) - 4);
      6'h0F: return {16'h0, 8'h01, m_intl};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [191:0] m_base();
    logic [191:0] r;
    for (int n = 0; n < 6; n++) r[32*n +: 32] = m_bar_rd(n);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cmd = 0; m_perr = 0; m_mab = 0; m_tab = 0;
      m_cache = 0; m_lat = 0; m_intl = 0;
      for (int n = 0; n < 6; n++) m_bar[n] = 0;
      exp_ack = 0; exp_rdata = 0; exp_hit = 0;
    end else begin
      logic [31:0] w, v;
      logic [3:0]  be;
      for (int n = 0; n < 6; n++) begin
        exp_hit[n] = hit_valid && (m_mask(n) != 0) && (hit_io == (n == 0))
                  && ((n == 0) ? m_cmd[0] : m_cmd[1])
                  && ((hit_addr & m_mask(n)) == (m_bar[n] & m_mask(n)));
      end
      if (!exp_ack && cif.cfg_req) begin
        exp_ack = 1;
        w  = cif.cfg_wdata;
        be = cif.cfg_be;
        if (!cif.cfg_we) exp_rdata = m_read(cif.cfg_addr);
        else begin
          v = m_read(cif.cfg_addr);
          for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = w[8*b +: 8];
          case (cif.cfg_addr)
            6'h01: begin
              m_cmd = v[15:0] & 16'h0547;
              if (be[3]) begin
                if (w[31]) m_perr = 0;
                if (w[29]) m_mab  = 0;
                if (w[28]) m_tab  = 0;
              end
            end
            6'h03: begin m_cache = v[7:0]; m_lat = v[15:8]; end
            6'h0F: m_intl = v[7:0];
            6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09: begin
              // Unwritten bytes keep raw stored content, not the readback.
              v = m_bar[int'(cif.cfg_addr) - 4];
              for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = w[8*b +: 8];
              m_bar[int'(cif.cfg_addr) - 4] = v;
            end
            default: ;
          endcase
        end
      end else begin
        exp_ack = 0;
      end
      if (set_perr)   m_perr = 1;
      if (set_mabort) m_mab  = 1;
      if (set_tabort) m_tab  = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ack",      192'(cif.cfg_ack), 192'(exp_ack));
      chk("rdata",    192'(cif.cfg_rdata), 192'(exp_rdata));
      chk("cmd_bits", 192'({cmd_intx_dis, cmd_serr_en, cmd_perr_en, cmd_master_en, cmd_mem_en, cmd_io_en}),
                      192'({m_cmd[10], m_cmd[8], m_cmd[6], m_cmd[2], m_cmd[1], m_cmd[0]}));
      chk("bar_base", bar_base, m_base());
      chk("bar_hit",  192'(bar_hit), 192'(exp_hit));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_access(input logic we, input logic [5:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, input logic pulse_ma,
                            output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cif.cfg_req = 1; cif.cfg_we = we; cif.cfg_addr = addr; cif.cfg_be = be; cif.cfg_wdata = wd;
    if (pulse_ma) set_mabort = 1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (pulse_ma) set_mabort = 0;
      if (cif.cfg_ack) break;
    end
    if (!cif.cfg_ack) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: no ack for addr %0h after %0d cycles", addr, lat);
    end
    rd = cif.cfg_rdata;
    cif.cfg_req = 0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r; int l;
    cfg_access(1'b1, a, be, d, 1'b0, r, l);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] r; int l;
    cfg_access(1'b0, a, 4'h0, 32'h0, 1'b0, r, l);
    chk(name, 192'(r), 192'(exp));
  endtask

  logic done;

  initial begin
    logic [31:0] r;
    int l;
    rst = 1;
    cif.cfg_req = 0; cif.cfg_we = 0; cif.cfg_addr = 0; cif.cfg_be = 0; cif.cfg_wdata = 0;
    int_status = 0; set_mabort = 0; set_tabort = 0; set_perr = 0;
    hit_valid = 0; hit_io = 0; hit_addr = 0;
    done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    chk("rst_ack",   192'(cif.cfg_ack), 192'(0));
    chk("rst_rdata", 192'(cif.cfg_rdata), 192'(0));
    chk("rst_hit",   192'(bar_hit), 192'(0));
    chk("rst_cmd",   192'({cmd_io_en, cmd_mem_en, cmd_master_en, cmd_perr_en, cmd_serr_en, cmd_intx_dis}), 192'(0));
    chk("rst_bar0",  192'(bar_base[31:0]), 192'(32'h0000_0001));

    // ID registers and one-cycle ack latency
    cfg_access(1'b0, 6'h00, 4'h0, 32'h0, 1'b0, r, l);
    chk("id", 192'(r), 192'(32'h0300_10EE));
    chk("ack_latency", 192'(l), 192'(1));
    rd_chk("class", 6'h02, 32'h0B40_0000);
    rd_chk("intpin", 6'h0F, 32'h0000_0100);

    // BAR sizing and readback
    wr(6'h04, 4'hF, 32'hFFFF_FFFF);
    rd_chk("bar0_size", 6'h04, 32'hFFFF_FFF1);
    wr(6'h05, 4'hF, 32'hFFFF_FFFF);
    rd_chk("bar1_size", 6'h05, 32'hFFFF_F008);
    wr(6'h06, 4'hF, 32'hFFFF_FFFF);
    rd_chk("bar2_absent", 6'h06, 32'h0);
    wr(6'h04, 4'hF, 32'h0000_1234);
    rd_chk("bar0_val", 6'h04, 32'h0000_1231);
    wr(6'h0A, 4'hF, 32'hFFFF_FFFF);
    rd_chk("unmapped", 6'h0A, 32'h0);

    // Command write with low byte enables only
    wr(6'h01, 4'b0011, 32'hFFFF_0547);
    rd_chk("cmd", 6'h01, 32'h0000_0547);
    chk("cmd_outs", 192'({cmd_io_en, cmd_mem_en, cmd_master_en, cmd_perr_en, cmd_serr_en, cmd_intx_dis}),
        192'(6'b111111));

    // RW1C and set-wins
    @(posedge clk); #1 set_mabort = 1;
    @(posedge clk); #1 set_mabort = 0;
    rd_chk("mabort_set", 6'h01, 32'h2000_0547);
    wr(6'h01, 4'b0100, 32'hFFFF_FFFF);
    rd_chk("mabort_be_keep", 6'h01, 32'h2000_0547);
    wr(6'h01, 4'b1000, 32'h2000_0000);
    rd_chk("mabort_clr", 6'h01, 32'h0000_0547);
    @(posedge clk); #1 set_mabort = 1;
    @(posedge clk); #1 set_mabort = 0;
    cfg_access(1'b1, 6'h01, 4'b1000, 32'h2000_0000, 1'b1, r, l);
    rd_chk("mabort_set_wins", 6'h01, 32'h2000_0547);

    // Address decode
    wr(6'h04, 4'hF, 32'h0000_1230);
    @(posedge clk); #1 hit_valid = 1; hit_io = 1; hit_addr = 32'h0000_123C;
    @(posedge clk); #1 chk("hit_io", 192'(bar_hit), 192'(6'b000001));
    hit_addr = 32'h0000_1240;
    @(posedge clk); #1 chk("miss_io", 192'(bar_hit), 192'(6'b000000));
    hit_addr = 32'h0000_123C;
    wr(6'h01, 4'b0011, 32'h0000_0546);
    @(posedge clk); #1 chk("hit_io_dis", 192'(bar_hit), 192'(6'b000000));
    wr(6'h05, 4'hF, 32'hABCD_E000);
    hit_io = 0; hit_addr = 32'hABCD_E7FF;
    @(posedge clk); #1 chk("hit_mem", 192'(bar_hit), 192'(6'b000010));
    hit_valid = 0;
    wr(6'h01, 4'b0011, 32'h0000_0547);

    // Reset during ack
    @(posedge clk); #1 cif.cfg_req = 1; cif.cfg_we = 0; cif.cfg_addr = 6'h00;
    @(posedge clk); #1 chk("ack_before_rst", 192'(cif.cfg_ack), 192'(1));
    rst = 1;
    #1 chk("ack_in_rst", 192'(cif.cfg_ack), 192'(0));
    chk("cmd_in_rst", 192'({cmd_io_en, cmd_mem_en, cmd_master_en, cmd_perr_en, cmd_serr_en, cmd_intx_dis}), 192'(0));
    cif.cfg_req = 0;
    @(posedge clk); #1 rst = 0;
    rd_chk("bar0_after_rst", 6'h04, 32'h0000_0001);

    // Randomized phase
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [5:0] a;
          logic [31:0] d;
          a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(4, 5)) : 6'($urandom_range(0, 15));
          d = $urandom;
          if (a == 6'h01 && $urandom_range(0, 1) == 1) d[15:0] = 16'h0003;
          cfg_access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d, 1'b0, r, l);
          if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          int_status = 1'($urandom_range(0, 1));
          set_mabort = ($urandom_range(0, 7) == 0);
          set_tabort = ($urandom_range(0, 7) == 0);
          set_perr   = ($urandom_range(0, 7) == 0);
          hit_valid  = 1'($urandom_range(0, 1));
          hit_io     = 1'($urandom_range(0, 1));
          hit_addr   = ($urandom_range(0, 1) == 1)
                     ? (m_bar[hit_io ? 0 : 1] ^ 32'($urandom_range(0, 8191)))
                     : $urandom;
        end
        set_mabort = 0; set_tabort = 0; set_perr = 0; hit_valid = 0;
      end
    join

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_cfg_space.md
Name: pci_cfg_space

Overview:
- Parametrised PCI Type-0 configuration space target. Replaces the fixed ID/class constant block with a full register file.
- Contents: ID and class registers, command/status, cache line, latency timer, up to 6 sized BARs, subsystem IDs, interrupt line/pin.
- Sits between the PCI target state machine (config accesses, valid/ack handshake) and the address decode path, which gets registered per-BAR hit flags.

Parameters:
- VENDOR_ID, 16'h10EE, vendor ID (RO).
- DEVICE_ID, 16'h0300, device ID (RO).
- CLASS_REV, 32'h0B40_0000, class code [31:8] and revision [7:0] (RO).
- SUBSYS_ID, 32'h0000_0000, subsystem ID [31:16] and subsystem vendor [15:0] (RO).
- NUM_BARS, 1, implemented BARs (1..6); BARs at index >= NUM_BARS read 0.
- BAR_MASKS, {6{32'hFFFF_FFF0}}, packed 6x32 size masks; BARn = bits [32n+31:32n]; 32'h0 = BAR absent.
- BAR_IO, 6'b000001, per-BAR: 1 = I/O space, 0 = memory.
- BAR_PREF, 6'b000000, per-BAR memory prefetchable bit (ignored for I/O).
- INT_PIN, 8'h01, interrupt pin value (RO).

Ports:
- CLK, input, 1, clock.
- RST, input, 1, asynchronous active-high reset.
- CFG_REQ, input, 1, config access request; held until CFG_ACK.
- CFG_WE, input, 1, 1 = write, 0 = read.
- CFG_ADDR, input, 6, dword index (config byte address [7:2]).
- CFG_BE, input, 4, byte enables, active-high.
- CFG_WDATA, input, 32, write data.
- CFG_RDATA, output, 32, read data, valid while CFG_ACK = 1.
- CFG_ACK, output, 1, one-cycle completion pulse.
- CMD_IO_EN, CMD_MEM_EN, CMD_MASTER_EN, CMD_PERR_EN, CMD_SERR_EN, CMD_INTX_DIS, output, 1 each, command bits 0, 1, 2, 6, 8, 10.
- BAR_BASE, output, 192, packed BAR registers as read back.
- INT_STATUS, input, 1, live interrupt pending, reported at status bit 19.
- SET_MABORT, SET_TABORT, SET_PERR, input, 1 each, single-cycle set pulses for status bits 29, 28, 31.
- HIT_VALID, input, 1, address qualifier for decode.
- HIT_IO, input, 1, address space of HIT_ADDR: 1 = I/O.
- HIT_ADDR, input, 32, address to decode.
- BAR_HIT, output, 6, registered per-BAR hit.

Behaviour:
- Reset: CFG_ACK = 0; CFG_RDATA = 0; BAR_HIT = 0; command = 0; status RW1C bits = 0; cache line = 0; latency timer = 0; interrupt line = 0; BAR address bits = 0. All CMD_* outputs are 0.
- FSM, two states:
  - IDLE: if CFG_REQ = 1, perform the access this cycle and go to ACK.
  - ACK: CFG_ACK = 1 for exactly one cycle, then go to IDLE.
  - CFG_REQ is not sampled in ACK, so a continuously held request completes every second cycle.
  - Read latency is 1 cycle: CFG_RDATA is registered and held until the next completed read.
- Register map (dword index):
  - 0x00: {DEVICE_ID, VENDOR_ID}, RO.
  - 0x01: {status, command}.
    - Command writable bits are 0, 1, 2, 6, 8, 10; all other command bits read 0.
    - Status bit 19 = INT_STATUS.
    - Status bits 28, 29, 31 are RW1C.
    - Other status bits read 0.
  - 0x02: CLASS_REV, RO.
  - 0x03: {8'h00 BIST, 8'h00 header type, latency timer RW, cache line RW}.
  - 0x04..0x09: BAR0..BAR5.
    - Readback = (stored & mask) | type bits.
    - Type bits: I/O BAR = 2'b01 in [1:0]; memory BAR = {pref, 2'b00, 1'b0} in [3:0].
    - Only bits set in the mask are writable, so writing FFFF_FFFF and reading back returns mask | type (BAR sizing).
  - 0x0B: SUBSYS_ID, RO.
  - 0x0F: {16'h0000, INT_PIN, interrupt line RW}.
  - Every other index reads 0. Writes to it are ignored but still acknowledged.
- Byte enables: writes update only bytes with CFG_BE[i] = 1, including RW1C bytes. Reads ignore CFG_BE.
- RW1C vs set pulse: if a set pulse and a write-1-to-clear hit the same bit in the same cycle, set wins and the bit stays 1.
- BAR_HIT[n] is registered one cycle after HIT_VALID. It is 1 when all of the following hold:
  - HIT_VALID = 1;
  - n < NUM_BARS and BAR_MASKS[n] != 0;
  - HIT_IO == BAR_IO[n];
  - the matching enable is set: CMD_IO_EN for I/O BARs, CMD_MEM_EN for memory BARs;
  - (HIT_ADDR & mask) == (BAR & mask).
  - Otherwise BAR_HIT[n] = 0.
- Reset mid-access: the FSM returns to IDLE, no ACK is issued, and the requester reissues the access.

Test Plan:
1. Read 0x00, 0x02, 0x0F after reset -> 0300_10EE, 0B40_0000, 0000_0100; CFG_ACK high exactly one cycle, one cycle after CFG_REQ.
2. BAR0 (I/O, mask FFFF_FFF0): write FFFF_FFFF, read 0x04 -> FFFF_FFF1. Write 0000_1234, read -> 0000_1231.
3. Write 0x01 = FFFF_0547 with BE = 4'b0011 -> command reads 0x0547. CMD_IO_EN = 1, CMD_MEM_EN = 1, CMD_MASTER_EN = 1, CMD_INTX_DIS = 1; status unchanged.
4. Pulse SET_MABORT -> bit 29 = 1. Write 0x01 = 2000_0000 with BE = 4'b1000 -> bit 29 = 0. Repeat with SET_MABORT in the same cycle as the write -> bit 29 stays 1.
5. BAR0 = 0000_1230, CMD_IO_EN = 1. HIT_IO = 1, HIT_ADDR = 0000_123C -> BAR_HIT = 000001 next cycle. HIT_ADDR = 0000_1240 -> 0. CMD_IO_EN = 0 -> 0.
6. Assert RST while in ACK state -> CFG_ACK = 0 immediately, command = 0, BAR0 reads 0000_0001.
